instr_fetch_unit: RTL
=====================

# instr_fetch_unit

- Instruction-fetch (IF) stage of the 5-stage pipeline; it drives the address side of the byte-addressed, little-endian, combinationally-read instruction memory.
- Owns the PC and the IF/ID pipeline register.
- Handles stall and branch/jump redirect.
- Stops fetching when it reads the all-zero halt word.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports (single clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  byte address to instruction memory; equals the PC register
- imem_instr  in  32  instruction word returned combinationally for imem_addr in the same cycle
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  branch/jump resolved taken; load redirect_pc
- redirect_pc  in  32  target byte address
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  32  PC of the IF/ID instruction
- ifid_pc_plus4  out  32  ifid_pc + 4
- ifid_instr  out  32  instruction word (NOP when invalid)
- halted  out  1  fetch stopped on halt word
- fetch_count  out  32  number of instructions passed into IF/ID with valid=1

## Operation
- States: RUN, HALT.
- Per-edge priority: rst > redirect_valid > stall > halt detect > normal advance.
- rst: pc=RESET_PC, state=RUN, ifid_valid=0, ifid_instr=32'h0000_0013, ifid_pc=0, ifid_pc_plus4=0, halted=0, fetch_count=0.
- redirect_valid (either state):
  - pc = {redirect_pc[31:2], 2'b00}
  - ifid_valid=0, ifid_instr=NOP
  - state=RUN, halted=0
  - overrides stall in the same cycle
- stall (RUN, no redirect): pc, IF/ID and fetch_count hold.
- RUN, imem_instr == 32'h0000_0000:
  - state=HALT, halted=1
  - pc holds
  - ifid_valid=0, ifid_instr=NOP
  - the halt word is never passed downstream
- RUN, normal advance:
  - ifid_pc=pc, ifid_pc_plus4=pc+4, ifid_instr=imem_instr, ifid_valid=1
  - pc = pc+4
  - fetch_count+1
- HALT, no redirect: pc holds, ifid_valid=0, fetch_count holds. stall has no effect.
- Arithmetic: all 32-bit, modulo 2^32. pc 32'hFFFF_FFFC advances to 0. fetch_count wraps to 0.
- pc[1:0] is always 00.

## Timing
- Fetch latency is one cycle. The word at address A (presented while pc==A) appears on ifid_* after the next rising edge.
- Redirect penalty is one bubble. On the edge with redirect_valid, IF/ID gets a bubble. The target instruction reaches IF/ID on the following edge.
- halted rises on the edge that samples the halt word. It falls on the edge that samples redirect_valid.
- No combinational path from inputs to outputs; imem_addr depends only on the pc register.
- rst asserted mid-stream (any state): outputs take reset values on that edge; in-flight IF/ID content is discarded.

## Structure
- Shared pipeline package:
  - NOP_INSTR = 32'h0000_0013
  - HALT_INSTR = 32'h0000_0000
  - fetch state encoding (RUN, HALT)
  - IF/ID bundle fields (valid, pc, pc_plus4, instr)
- One sub-module: if_id_register.
  - Holds the IF/ID bundle.
  - Inputs: load, bubble, and the reset to NOP.
  - ID stage reuses it for the ID/EX bubble convention.
- PC register, state register, fetch_count and next-PC mux live in instr_fetch_unit.

## Test plan
- Program run:
  - Stimulus: RESET_PC=0; memory 0:0x00100013, 4:0x00228313, 8:0x00238313, 12:0x00000000.
  - Response: ifid shows (pc 0, 0x00100013), (4, 0x00228313), (8, 0x00238313) on consecutive edges, with ifid_pc_plus4 4/8/12. Next edge: halted=1, ifid_valid=0, imem_addr stays 12, fetch_count=3.
- Stall:
  - Stimulus: stall=1 for 2 cycles while pc=4.
  - Response: imem_addr stays 4; ifid holds (0, 0x00100013); fetch_count unchanged. After release, (4, 0x00228313) appears.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc=0x40 while pc=8.
  - Response: next edge imem_addr=0x40, ifid_valid=0. The following edge has ifid_pc=0x40.
- Redirect + stall in the same cycle:
  - Response: redirect wins; imem_addr=0x40, ifid_valid=0.
- Resume from HALT:
  - Stimulus: in HALT at pc=12, redirect_pc=0x4.
  - Response: halted=0, state RUN, imem_addr=4; ifid_pc=4 one edge later.
- Boundaries:
  - redirect_pc=0x43 → imem_addr=0x40.
  - RESET_PC=32'hFFFF_FFFC with a nonzero word there → after one advance, imem_addr=0.
  - rst asserted while halted → halted=0, imem_addr=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: instruction constants,
// fetch state encoding and the IF/ID bundle layout.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'h0000_0004;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_bundle_t;

  // Instruction addresses are word aligned; the low two bits are forced clear.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic ifid_bundle_t ifid_reset_value();
    ifid_bundle_t b;
    b.valid    = 1'b0;
    b.pc       = 32'h0000_0000;
    b.pc_plus4 = 32'h0000_0000;
    b.instr    = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory address side, hazard and
// redirect controls, and the IF/ID outputs seen by decode.
interface instr_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output ifid_valid,
    output ifid_pc,
    output ifid_pc_plus4,
    output ifid_instr,
    output halted,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_pc,
    input  ifid_pc_plus4,
    input  ifid_instr,
    input  halted,
    input  fetch_count
  );

endinterface

// File: rtl/instr_fetch_unit_if_id_register.sv
// Generic pipeline bundle register: reset and bubble both leave a NOP with
// valid clear; bubble wins over load so a flush cannot be overwritten.
module if_id_register
  import instr_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  ifid_bundle_t d,
  output ifid_bundle_t q
);

  ifid_bundle_t ifid_d;
  ifid_bundle_t ifid_q;

  // Bubble keeps the PC fields so debug views still show where the slot came from.
  always_comb begin
    ifid_d = ifid_q;
    if (bubble) begin
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
    end else if (load) begin
      ifid_d = d;
    end else begin
      ifid_d = ifid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= ifid_reset_value();
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q = ifid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC, RUN/HALT state, fetch counter and next-PC
// selection; the fetched word is latched into the IF/ID register.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_unit_if.master     bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         halted_q, halted_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic         ifid_load;
  logic         ifid_bubble;
  ifid_bundle_t ifid_in;
  ifid_bundle_t ifid_out;

  // Next-state selection, priority redirect > stall > halt detect > advance.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    halted_d       = halted_q;
    fetch_count_d  = fetch_count_q;
    ifid_load      = 1'b0;
    ifid_bubble    = 1'b0;
    ifid_in.valid    = 1'b1;
    ifid_in.pc       = pc_q;
    ifid_in.pc_plus4 = pc_q + PC_STEP;
    ifid_in.instr    = bus.imem_instr;

    if (bus.redirect_valid) begin
      pc_d        = align_pc(bus.redirect_pc);
      state_d     = ST_RUN;
      halted_d    = 1'b0;
      ifid_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.stall) begin
            pc_d = pc_q;
          end else if (bus.imem_instr == HALT_INSTR) begin
            // The halt word itself never enters IF/ID.
            state_d     = ST_HALT;
            halted_d    = 1'b1;
            ifid_bubble = 1'b1;
          end else begin
            pc_d          = pc_q + PC_STEP;
            fetch_count_d = fetch_count_q + 32'h0000_0001;
            ifid_load     = 1'b1;
          end
        end
        ST_HALT: begin
          ifid_bubble = 1'b1;
        end
        default: begin
          state_d     = ST_RUN;
          ifid_bubble = 1'b1;
        end
      endcase
    end
  end

  // Fetch state, PC and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= align_pc(RESET_PC);
      halted_q      <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_register u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_in),
    .q      (ifid_out)
  );

  assign bus.imem_addr     = pc_q;
  assign bus.ifid_valid    = ifid_out.valid;
  assign bus.ifid_pc       = ifid_out.pc;
  assign bus.ifid_pc_plus4 = ifid_out.pc_plus4;
  assign bus.ifid_instr    = ifid_out.instr;
  assign bus.halted        = halted_q;
  assign bus.fetch_count   = fetch_count_q;

endmodule
